io_timer: RTL and testbench
===========================

Name: io_timer

Overview:
- Memory-mapped timer/counter peripheral; the responder side of the CPU I/O bus (bus_data, bus_addr, read, write).
- The CPU issues I/O reads and writes; this block decodes an address window, accepts register writes, and drives read data onto the shared data bus.
- Provides a prescaled up-counter, a compare match with a sticky flag, and an interrupt-request level output.

Parameters:
DATA_WIDTH, 16, width of bus_data and of the PRESC, COMPARE and COUNT registers
ADDR_WIDTH, 8, width of bus_addr
BASE_ADDR, 8'hF0, address of register 0; the block decodes BASE_ADDR..BASE_ADDR+4

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
bus_data  inout  DATA_WIDTH  shared data bus; driven only during a decoded read, otherwise high-Z
bus_addr  input  ADDR_WIDTH  I/O address from the CPU
read  input  1  CPU read strobe, level
write  input  1  CPU write strobe, level
irq  output  1  interrupt request, equal to STATUS.MATCH & CTRL.IE

Behaviour:
- Register map, as an offset from BASE_ADDR:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE; other bits read 0.
  - 1 PRESC: prescaler divisor.
  - 2 COMPARE: match value.
  - 3 COUNT: read/write.
  - 4 STATUS: bit0 MATCH; write-1-to-clear.
- hit = (bus_addr - BASE_ADDR) <= 4, computed without wrap; addresses outside the window are ignored.
- Reset (reset=0, asynchronous): all registers and the prescaler counter go to 0, irq=0, bus_data=Z.
- Reads:
  - When read=1 & write=0 & hit, bus_data is combinationally driven with the addressed register, zero-extended.
  - The value is valid in the same cycle, so the CPU latches it at the next clk edge.
- Writes:
  - When write=1 & hit, the addressed register is updated at the rising clk edge from bus_data.
  - If read=1 and write=1 together, the access is treated as a write and bus_data is not driven.
- Prescaler (pcnt, DATA_WIDTH bits):
  - While EN=1, each cycle: if pcnt==PRESC then pcnt<=0 and tick=1, else pcnt<=pcnt+1.
  - PRESC=0 gives a tick every cycle.
  - While EN=0, pcnt holds.
  - Any write to CTRL or PRESC clears pcnt.
- On tick:
  - If COUNT==COMPARE: MATCH<=1.
    - RELOAD=1: COUNT<=0.
    - RELOAD=0: COUNT holds and EN<=0 (one-shot).
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^DATA_WIDTH.
  - If COMPARE is written below the current COUNT, the counter wraps through 0 before matching.
- Simultaneous events:
  - A CPU write to COUNT or CTRL in the same cycle as a tick takes priority over the hardware update of that register.
  - A STATUS write-1-to-clear in the same cycle as a hardware MATCH set: the set wins, and MATCH stays 1.
  - Writing 0 to STATUS.bit0 has no effect.
- irq is a combinational function of the MATCH and IE registers, so it is glitch-free relative to clk. irq drops in the cycle after a successful clear.
- A reset during counting aborts immediately; on release the block restarts from the all-zero state.

Test Plan:
- Reset, then read offsets 0-4 at BASE_ADDR=F0 -> each reads 0000, irq=0; a read at addr EF or F5 -> bus_data stays Z.
- Write PRESC=2, COMPARE=3, CTRL=3 (EN, RELOAD) -> COUNT increments every 3 cycles. At COUNT=3 the next tick sets MATCH=1 and COUNT=0. A periodic match occurs every 12 cycles.
- CTRL=5 (EN, IE, one-shot), PRESC=0, COMPARE=5 -> the match fires 6 cycles after enable. Then EN reads 0, COUNT holds at 5, and irq=1. Writing 0001 to STATUS -> MATCH=0 and irq=0 on the next cycle.
- Write COUNT=FFFE with COMPARE=0001, PRESC=0, EN=1 -> COUNT goes FFFF, 0000, 0001, then the match occurs.
- Assert a STATUS write 0001 in the same cycle as a match tick -> MATCH remains 1. Assert read=1 and write=1 together at F2 -> COMPARE is written and bus_data is not driven.
- Pull reset low mid-count at COUNT=0007 -> all registers are 0 immediately without waiting for clk; after release, EN=0 and COUNT stays 0.

Source files
------------

// File: rtl/io_timer.sv
// Memory-mapped timer/counter: prescaled up-counter with a compare match, a sticky
// MATCH flag and an interrupt level, on the CPU I/O bus (bus_data/bus_addr/read/write).
module io_timer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  logic [DATA_WIDTH-1:0] bus_data,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  read,
  input  logic                  write,
  output logic                  irq
);

  logic                  en_q, en_d;
  logic                  reload_q, reload_d;
  logic                  ie_q, ie_d;
  logic                  match_q, match_d;
  logic [DATA_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] pcnt_q, pcnt_d;

  logic [ADDR_WIDTH-1:0] offs;
  logic                  hit;
  logic                  wr_ctrl, wr_presc, wr_compare, wr_count, wr_status;
  logic                  tick, cmp_hit;
  logic                  drive;
  logic [DATA_WIDTH-1:0] rdata;

  // The lower-bound test keeps addresses just below BASE_ADDR from wrapping into the window.
  assign offs = bus_addr - BASE_ADDR;
  assign hit  = (bus_addr >= BASE_ADDR) && (offs <= ADDR_WIDTH'(4));

  assign wr_ctrl    = write && hit && (offs[2:0] == 3'd0);
  assign wr_presc   = write && hit && (offs[2:0] == 3'd1);
  assign wr_compare = write && hit && (offs[2:0] == 3'd2);
  assign wr_count   = write && hit && (offs[2:0] == 3'd3);
  assign wr_status  = write && hit && (offs[2:0] == 3'd4);

  assign tick    = en_q && (pcnt_q == presc_q);
  assign cmp_hit = tick && (count_q == compare_q);

  always_comb begin
    rdata = '0;
    case (offs[2:0])
      3'd0:    rdata[2:0] = {ie_q, reload_q, en_q};
      3'd1:    rdata = presc_q;
      3'd2:    rdata = compare_q;
      3'd3:    rdata = count_q;
      3'd4:    rdata[0] = match_q;
      default: rdata = '0;
    endcase
  end

  assign drive    = read && !write && hit && reset;
  assign bus_data = drive ? rdata : 'z;
  assign irq      = match_q && ie_q;

  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    ie_d      = ie_q;
    match_d   = match_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    count_d   = count_q;
    pcnt_d    = pcnt_q;

    if (wr_ctrl || wr_presc) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + DATA_WIDTH'(1);
    end

    if (tick) begin
      if (cmp_hit) begin
        if (reload_q) count_d = '0;
        else          en_d    = 1'b0;
      end else begin
        count_d = count_q + DATA_WIDTH'(1);
      end
    end

    // CPU writes are applied after the hardware update so they win; a MATCH set beats a clear.
    if (wr_ctrl) begin
      en_d     = bus_data[0];
      reload_d = bus_data[1];
      ie_d     = bus_data[2];
    end
    if (wr_presc)   presc_d   = bus_data;
    if (wr_compare) compare_d = bus_data;
    if (wr_count)   count_d   = bus_data;
    if (wr_status && bus_data[0]) match_d = 1'b0;
    if (cmp_hit)    match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      ie_q      <= 1'b0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      compare_q <= '0;
      count_q   <= '0;
      pcnt_q    <= '0;
    end else begin
      en_q      <= en_d;
      reload_q  <= reload_d;
      ie_q      <= ie_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer; the bus is pulled up so an undriven bus reads FFFF.
module tb_io_timer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic        oe;
  logic [15:0] wdata;
  logic        irq;
  tri1  [15:0] bus;

  int unsigned n_vec;
  int unsigned n_err;
  logic [15:0] rv;

  assign bus = oe ? wdata : 'z;

  io_timer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .BASE_ADDR (8'hF0)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus_data(bus),
    .bus_addr(addr),
    .read    (rd),
    .write   (wr),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    #1 d = bus;
    #1 rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    oe    = 1'b1;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    oe = 1'b0;
  endtask

  initial begin
    logic [15:0] wrap_tab [5];
    wrap_tab = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001};
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    addr  = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    oe    = 1'b0;
    wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state and address window
    rd_chk("rst_ctrl",    8'hF0, 16'h0000);
    rd_chk("rst_presc",   8'hF1, 16'h0000);
    rd_chk("rst_compare", 8'hF2, 16'h0000);
    rd_chk("rst_count",   8'hF3, 16'h0000);
    rd_chk("rst_status",  8'hF4, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    rd_chk("z_at_EF", 8'hEF, 16'hFFFF);
    rd_chk("z_at_F5", 8'hF5, 16'hFFFF);
    bus_wr(8'hEF, 16'h0007);
    bus_wr(8'hF5, 16'h0007);
    rd_chk("ctrl_untouched", 8'hF0, 16'h0000);

    // periodic match: PRESC=2, COMPARE=3, reload
    bus_wr(8'hF1, 16'h0002);
    bus_wr(8'hF2, 16'h0003);
    bus_wr(8'hF0, 16'h0003);
    for (int k = 0; k < 24; k++)
      rd_chk($sformatf("per_count_%0d", k), 8'hF3, 16'((k % 12) / 3));
    rd_chk("per_status", 8'hF4, 16'h0001);
    bus_wr(8'hF0, 16'h0000);
    bus_wr(8'hF4, 16'h0001);
    rd_chk("per_status_clr", 8'hF4, 16'h0000);

    // one-shot with IE: PRESC=0, COMPARE=5
    bus_wr(8'hF1, 16'h0000);
    bus_wr(8'hF2, 16'h0005);
    bus_wr(8'hF3, 16'h0000);
    bus_wr(8'hF0, 16'h0005);
    for (int k = 0; k < 8; k++) begin
      rd_chk($sformatf("os_count_%0d", k), 8'hF3, (k <= 5) ? 16'(k) : 16'd5);
      chk($sformatf("os_irq_%0d", k), {15'd0, irq}, (k >= 6) ? 16'd1 : 16'd0);
    end
    rd_chk("os_status", 8'hF4, 16'h0001);
    rd_chk("os_ctrl",   8'hF0, 16'h0004);
    @(negedge clk);
    addr = 8'hF4; wdata = 16'h0001; oe = 1'b1; wr = 1'b1;
    #1 chk("os_irq_before_clr", {15'd0, irq}, 16'h0001);
    @(posedge clk);
    #1;
    wr = 1'b0; oe = 1'b0;
    chk("os_irq_after_clr", {15'd0, irq}, 16'h0000);
    rd_chk("os_count_hold", 8'hF3, 16'h0005);

    // wrap through zero before matching
    bus_wr(8'hF0, 16'h0000);
    bus_wr(8'hF2, 16'h0001);
    bus_wr(8'hF3, 16'hFFFE);
    bus_wr(8'hF0, 16'h0001);
    for (int k = 0; k < 5; k++)
      rd_chk($sformatf("wrap_count_%0d", k), 8'hF3, wrap_tab[k]);
    rd_chk("wrap_status", 8'hF4, 16'h0001);
    rd_chk("wrap_ctrl",   8'hF0, 16'h0000);
    chk("wrap_irq", {15'd0, irq}, 16'h0000);
    bus_wr(8'hF4, 16'h0001);

    // clear coinciding with a match tick: set wins
    bus_wr(8'hF3, 16'h0000);
    bus_wr(8'hF2, 16'h0002);
    bus_wr(8'hF0, 16'h0003);
    rd_chk("sim_count_0", 8'hF3, 16'h0000);
    rd_chk("sim_count_1", 8'hF3, 16'h0001);
    rd_chk("sim_count_2", 8'hF3, 16'h0002);
    rd_chk("sim_count_3", 8'hF3, 16'h0000);
    rd_chk("sim_status_set", 8'hF4, 16'h0001);
    bus_wr(8'hF4, 16'h0001);
    rd_chk("sim_status_kept", 8'hF4, 16'h0001);
    bus_wr(8'hF0, 16'h0000);
    bus_wr(8'hF4, 16'h0000);
    rd_chk("w0_no_effect", 8'hF4, 16'h0001);
    bus_wr(8'hF4, 16'h0001);
    rd_chk("sim_status_clr", 8'hF4, 16'h0000);

    // read and write together: treated as a write, bus not driven
    @(negedge clk);
    addr = 8'hF2; rd = 1'b1; wr = 1'b1; oe = 1'b0;
    #1 chk("rw_bus_z", bus, 16'hFFFF);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    rd_chk("rw_compare_ffff", 8'hF2, 16'hFFFF);
    @(negedge clk);
    addr = 8'hF2; wdata = 16'h1234; oe = 1'b1; rd = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; oe = 1'b0;
    rd_chk("rw_compare_1234", 8'hF2, 16'h1234);

    // asynchronous reset mid-count
    bus_wr(8'hF3, 16'h0000);
    bus_wr(8'hF1, 16'h0000);
    bus_wr(8'hF0, 16'h0001);
    for (int k = 0; k < 7; k++)
      rd_chk($sformatf("rc_count_%0d", k), 8'hF3, 16'(k));
    @(negedge clk);
    addr = 8'hF3; rd = 1'b1;
    #1 chk("rc_count_7", bus, 16'h0007);
    #1 rst_n = 1'b0;
    #1 chk("rc_bus_z_in_reset", bus, 16'hFFFF);
    chk("rc_irq_in_reset", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    #1 chk("rc_count_cleared", bus, 16'h0000);
    rd = 1'b0;
    rd_chk("rc_ctrl_after",    8'hF0, 16'h0000);
    rd_chk("rc_compare_after", 8'hF2, 16'h0000);
    repeat (3) @(negedge clk);
    rd_chk("rc_count_stays0",  8'hF3, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
